// File: rtl/sap1_run_ctrl_pkg.sv
// Shared constants and the sequencer state type for the SAP-1 run controller.
package sap1_run_ctrl_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int T_STATES = 5;

  localparam logic [ADDR_W-1:0] HLT_OPCODE = 4'hF;
  localparam logic [2:0]        HLT_T      = 3'd2;
  localparam logic [2:0]        T_LAST     = 3'(T_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_PAUSE,
    S_HALT,
    S_LD_WR,
    S_LD_ACK
  } state_e;

endpackage

// File: rtl/sap1_run_ctrl_if.sv
// Loader handshake and program-RAM write bus shared by the loader and the run controller.
interface sap1_run_ctrl_if;
  import sap1_run_ctrl_pkg::*;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              ram_sel;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport master (
    output ld_req, ld_addr, ld_data,
    input  ld_ack, ram_sel, ram_we, ram_addr, ram_data
  );

  modport slave (
    input  ld_req, ld_addr, ld_data,
    output ld_ack, ram_sel, ram_we, ram_addr, ram_data
  );

endinterface

// File: rtl/sap1_run_ctrl_ram_load_port.sv
// Loader side of the RAM arbiter: captures one write on start, strobes RAM_WE once,
// then holds LD_ACK until the loader drops its request.
module sap1_run_ctrl_ram_load_port
  import sap1_run_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              done_o,
  output logic              ld_ack_o,
  output logic              ram_sel_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o
);

  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    we_d   = 1'b0;
    ack_d  = ack_q;
    sel_d  = sel_q;
    addr_d = addr_q;
    data_d = data_q;
    if (start_i) begin
      we_d   = 1'b1;
      sel_d  = 1'b1;
      ack_d  = 1'b0;
      addr_d = ld_addr_i;
      data_d = ld_data_i;
    end else if (we_q) begin
      ack_d = 1'b1;
    end else if (ack_q && !ld_req_i) begin
      ack_d = 1'b0;
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      ack_q  <= 1'b0;
      sel_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      ack_q  <= ack_d;
      sel_q  <= sel_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Done is combinational so the main FSM leaves LD_ACK on the same edge RAM_SEL drops.
  assign done_o     = ack_q & ~ld_req_i;
  assign ld_ack_o   = ack_q;
  assign ram_sel_o  = sel_q;
  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_data_o = data_q;

endmodule

// File: rtl/sap1_run_ctrl.sv
// Run/halt/single-step sequencer for the SAP-1 core; gates the T-state counter and
// hands the program RAM to the external loader only while the CPU is stopped.
module sap1_run_ctrl
  import sap1_run_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic              stop_i,
  input  logic [ADDR_W-1:0] opcode_i,
  input  logic [2:0]        t_cnt_i,
  output logic              cu_ce_o,
  output logic              cpu_clr_o,
  output logic              halted_o,
  output logic              running_o,
  sap1_run_ctrl_if.slave    ld_bus
);

  state_e state_q, state_d;
  logic   stop_pend_q, stop_pend_d;
  logic   cu_ce_q, cpu_clr_q, halted_q, running_q;
  logic   ld_start, ld_done;
  logic   boundary, hlt_hit;

  assign boundary = cu_ce_q && (t_cnt_i == T_LAST);
  assign hlt_hit  = cu_ce_q && (t_cnt_i == HLT_T) && (opcode_i == HLT_OPCODE);

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    ld_start    = 1'b0;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (ld_bus.ld_req) begin
          state_d  = S_LD_WR;
          ld_start = 1'b1;
        end else if (run_i) begin
          state_d = S_RUN;
        end else if (step_i) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (hlt_hit) begin
          state_d = S_HALT;
        end else if (boundary && (stop_i || stop_pend_q)) begin
          state_d = S_PAUSE;
        end else if (stop_i) begin
          stop_pend_d = 1'b1;
        end
      end
      S_STEP: begin
        if (hlt_hit) begin
          state_d = S_HALT;
        end else if (boundary) begin
          state_d = S_PAUSE;
        end
      end
      S_HALT: begin
        if (ld_bus.ld_req) begin
          state_d  = S_LD_WR;
          ld_start = 1'b1;
        end else if (run_i) begin
          state_d = S_IDLE;
        end
      end
      S_LD_WR:  state_d = S_LD_ACK;
      S_LD_ACK: if (ld_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // A pending STOP only belongs to the instruction currently running.
    if (state_d != S_RUN) stop_pend_d = 1'b0;
  end

  // Outputs are registered from the next state so they change on the deciding edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      stop_pend_q <= 1'b0;
      cu_ce_q     <= 1'b0;
      cpu_clr_q   <= 1'b1;
      halted_q    <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      cu_ce_q     <= (state_d == S_RUN) || (state_d == S_STEP);
      running_q   <= (state_d == S_RUN) || (state_d == S_STEP);
      cpu_clr_q   <= (state_d == S_IDLE) || (state_d == S_LD_WR) || (state_d == S_LD_ACK);
      halted_q    <= (state_d == S_HALT);
    end
  end

  sap1_run_ctrl_ram_load_port u_load_port (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (ld_start),
    .ld_req_i   (ld_bus.ld_req),
    .ld_addr_i  (ld_bus.ld_addr),
    .ld_data_i  (ld_bus.ld_data),
    .done_o     (ld_done),
    .ld_ack_o   (ld_bus.ld_ack),
    .ram_sel_o  (ld_bus.ram_sel),
    .ram_we_o   (ld_bus.ram_we),
    .ram_addr_o (ld_bus.ram_addr),
    .ram_data_o (ld_bus.ram_data)
  );

  assign cu_ce_o   = cu_ce_q;
  assign cpu_clr_o = cpu_clr_q;
  assign halted_o  = halted_q;
  assign running_o = running_q;

endmodule
